cache_mem_responder: RTL and testbench

//   Memory-side responder for the cache's memory interface: word-addressed backing RAM serving

---
 rtl/cache_mem_responder.sv | 108 ++++++++++
 tb/tb_cache_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency word RAM behind a ready/valid memory port.
// Define MEM_RANGE_CHECK_EN to flag addresses beyond the RAM instead of wrapping them.
module cache_mem_responder #(
    parameter int width     = 32,
    parameter int addr_bits = 12,
    parameter int latency   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  logic             mem_write_enable_i,
    input  logic [width-1:0] mem_address_i,
    input  logic [width-1:0] mem_write_data_i,
    output logic             mem_ready_o,
    output logic             mem_valid_o,
    output logic [width-1:0] mem_read_data_o,
    output logic             mem_error_o
);
    localparam int depth = 2 ** addr_bits;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state, state_nx;
    logic [3:0]             cnt;
    logic                   we_q, oor_q;
    logic [addr_bits-1:0]   idx_q;
    logic [width-1:0]       data_q;
    logic [width-1:0]       ram [depth];
    logic                   accept, access, oor_in;
    logic                   we_now, oor_now;
    logic [addr_bits-1:0]   idx_now;
    logic [width-1:0]       data_now;
    logic                   unused_addr_lsb;

    if (latency < 1 || latency > 15) begin : g_bad_latency
        $error("cache_mem_responder: latency must be within 1..15");
    end

`ifdef MEM_RANGE_CHECK_EN
    assign oor_in = |mem_address_i[width-1:addr_bits+2];
`else
    logic unused_addr_hi;
    assign oor_in         = 1'b0;
    assign unused_addr_hi = ^mem_address_i[width-1:addr_bits+2];
`endif
    assign unused_addr_lsb = ^mem_address_i[1:0];

    assign accept = mem_req_i && mem_ready_o;
    assign access = !rst_i && state_nx == RESP;

    // With latency 1 the access happens in the accept cycle, so take the live request fields
    assign we_now   = state == IDLE ? mem_write_enable_i : we_q;
    assign oor_now  = state == IDLE ? oor_in : oor_q;
    assign idx_now  = state == IDLE ? mem_address_i[addr_bits+1:2] : idx_q;
    assign data_now = state == IDLE ? mem_write_data_i : data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // cnt holds the cycles left before the response; the last WAIT cycle sees 1
    always_comb begin
        state_nx = state == IDLE ? (accept ? (latency == 1 ? RESP : WAIT) : IDLE)
                 : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        mem_ready_o = state == IDLE && !rst_i;
        mem_valid_o = state == RESP;
`ifdef MEM_RANGE_CHECK_EN
        mem_error_o = state == RESP && oor_q;
`else
        mem_error_o = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt             <= '0;
            we_q            <= 1'b0;
            oor_q           <= 1'b0;
            idx_q           <= '0;
            data_q          <= '0;
            mem_read_data_o <= '0;
        end else begin
            if (accept) begin
                cnt    <= 4'(latency - 1);
                we_q   <= mem_write_enable_i;
                oor_q  <= oor_in;
                idx_q  <= mem_address_i[addr_bits+1:2];
                data_q <= mem_write_data_i;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !we_now && !oor_now)
                mem_read_data_o <= ram[idx_now];
        end
    end

    // RAM contents survive reset; access is already suppressed while rst_i is high
    always_ff @(posedge clk_i) begin
        if (access && we_now && !oor_now)
            ram[idx_now] <= data_now;
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized and directed checks of two responders (latency 3 and 1)
// against a word-array reference model.
module tb_cache_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req, we, ready, valid, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    int tests = 0, fails = 0;

    bit [31:0] mem_m [int];
    bit [31:0] last_rd [2];
    bit        last_known [2];

    cache_mem_responder #(.width(32), .addr_bits(12), .latency(3)) d0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .mem_write_enable_i(we[0]),
        .mem_address_i(addr[0]), .mem_write_data_i(wdata[0]), .mem_ready_o(ready[0]),
        .mem_valid_o(valid[0]), .mem_read_data_o(rdata[0]), .mem_error_o(err[0]));

    cache_mem_responder #(.width(32), .addr_bits(12), .latency(1)) d1 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .mem_write_enable_i(we[1]),
        .mem_address_i(addr[1]), .mem_write_data_i(wdata[1]), .mem_ready_o(ready[1]),
        .mem_valid_o(valid[1]), .mem_read_data_o(rdata[1]), .mem_error_o(err[1]));

    function automatic int lat_of(input int s);
        return s == 0 ? 3 : 1;
    endfunction

    function automatic bit out_of_range(input bit [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return |a[31:14];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model(input int s, input bit w, input bit [31:0] a, input bit [31:0] d,
                         output bit e, output bit known, output bit [31:0] r);
        int key;
        key = s * 4096 + int'(a[13:2]);
        e = out_of_range(a);
        if (!e) begin
            if (w)
                mem_m[key] = d;
            else if (mem_m.exists(key)) begin
                last_rd[s]    = mem_m[key];
                last_known[s] = 1'b1;
            end else
                last_known[s] = 1'b0;
        end
        known = last_known[s];
        r     = last_rd[s];
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_rd[s]    = '0;
            last_known[s] = 1'b1;
        end
    endtask

    // Drives one transaction from a negedge; returns observed latency and status, compares nothing
    task automatic txn(input int s, input bit w, input bit [31:0] a, input bit [31:0] d,
                       output int lat, output bit [31:0] r, output bit e,
                       output bit rdy_ok, output bit post_ok);
        int n = 0;
        while (!ready[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        @(posedge clk);
        #1 req[s] = 1'b0;
        lat = -1;
        rdy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready[s]) rdy_ok = 1'b0;
            if (valid[s]) begin
                lat = k;
                break;
            end
        end
        r = rdata[s];
        e = err[s];
        @(negedge clk);
        post_ok = !valid[s] && ready[s];
    endtask

    task automatic test_reset();
        int lat; bit [31:0] r, er; bit e, k, ro, po, ee;
        rst = 1'b1; req = '0; we = '0;
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0;
            wdata[s] = '0;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready_low: ready=%b expected 00", ready);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if (ready !== 2'b11 || valid !== 2'b00 || err !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b expected 11 00 00", ready, valid, err);
        end
        tests++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: %h %h expected 0", rdata[0], rdata[1]);
        end
        txn(0, 1'b0, 32'h0, 32'h0, lat, r, e, ro, po);
        model(0, 1'b0, 32'h0, 32'h0, ee, k, er);
        tests++;
        if (lat !== 3 || !ro || !po) begin
            fails++;
            $display("FAIL first_read_timing: lat=%0d ready_low=%0d after_ok=%0d expected 3 1 1", lat, ro, po);
        end
        tests++;
        if ($isunknown(r) || $isunknown(e)) begin
            fails++;
            $display("FAIL first_read_x: rdata=%h err=%b expected known values", r, e);
        end
    endtask

    task automatic test_write_read();
        int lat; bit [31:0] r, er; bit e, k, ro, po, ee;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, r, e, ro, po);
        model(0, 1'b1, 32'h10, 32'hDEADBEEF, ee, k, er);
        tests++;
        if (lat !== 3 || !ro || !po || e !== 1'b0) begin
            fails++;
            $display("FAIL write_ack: lat=%0d ready_low=%0d after_ok=%0d err=%b expected 3 1 1 0", lat, ro, po, e);
        end
        txn(0, 1'b0, 32'h10, 32'h0, lat, r, e, ro, po);
        model(0, 1'b0, 32'h10, 32'h0, ee, k, er);
        tests++;
        if (lat !== 3 || !ro || !po || r !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_after_write: lat=%0d ready_low=%0d data=%h expected 3 1 deadbeef", lat, ro, r);
        end
    endtask

    task automatic test_hold();
        int lat; bit [31:0] r, er, d4, d8; bit e, k, ro, po, ee;
        int acc[$];
        bit [31:0] got[$];
        d4 = $urandom; d8 = $urandom;
        txn(0, 1'b1, 32'h4, d4, lat, r, e, ro, po);
        model(0, 1'b1, 32'h4, d4, ee, k, er);
        txn(0, 1'b1, 32'h8, d8, lat, r, e, ro, po);
        model(0, 1'b1, 32'h8, d8, ee, k, er);
        for (int i = 0; i < 16; i++) begin
            if (valid[0]) got.push_back(rdata[0]);
            req[0] = i < 10;
            we[0] = 1'b0;
            addr[0] = acc.size() % 2 == 1 ? 32'h8 : 32'h4;
            if (req[0] && ready[0]) acc.push_back(i);
            @(negedge clk);
        end
        req[0] = 1'b0;
        model(0, 1'b0, 32'h4, 32'h0, ee, k, er);
        model(0, 1'b0, 32'h8, 32'h0, ee, k, er);
        model(0, 1'b0, 32'h4, 32'h0, ee, k, er);
        tests++;
        if (acc.size() != 3 || got.size() != 3) begin
            fails++;
            $display("FAIL hold_counts: accepts=%0d responses=%0d expected 3 3", acc.size(), got.size());
        end else begin
            tests++;
            if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
                fails++;
                $display("FAIL hold_spacing: accepts at %0d %0d %0d expected spacing 4", acc[0], acc[1], acc[2]);
            end
            tests++;
            if (got[0] !== d4 || got[1] !== d8 || got[2] !== d4) begin
                fails++;
                $display("FAIL hold_order: %h %h %h expected %h %h %h", got[0], got[1], got[2], d4, d8, d4);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, vs; bit [31:0] r, er, v0; bit e, k, ro, po, ee, rdy_bad;
        v0 = $urandom;
        if (v0 == 32'h12345678) v0 = 32'h0BADF00D;
        txn(0, 1'b1, 32'h20, v0, lat, r, e, ro, po);
        model(0, 1'b1, 32'h20, v0, ee, k, er);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vs = 0;
        rdy_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (valid[0]) vs++;
            if (ready[0]) rdy_bad = 1'b1;
        end
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            if (valid[0]) vs++;
        end
        tests++;
        if (vs != 0 || rdy_bad) begin
            fails++;
            $display("FAIL abort_no_pulse: valid_cycles=%0d ready_in_reset=%0d expected 0 0", vs, rdy_bad);
        end
        tests++;
        if (rdata[0] !== 32'h0 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_state: rdata=%h ready=%b expected 0 1", rdata[0], ready[0]);
        end
        txn(0, 1'b0, 32'h20, 32'h0, lat, r, e, ro, po);
        model(0, 1'b0, 32'h20, 32'h0, ee, k, er);
        tests++;
        if (r !== er || lat !== 3) begin
            fails++;
            $display("FAIL abort_not_committed: data=%h lat=%0d expected %h 3", r, lat, er);
        end
    endtask

    task automatic test_wrap();
        int lat; bit [31:0] r, er; bit e, k, ro, po, ee;
        txn(0, 1'b1, 32'h4004, 32'hA5A5A5A5, lat, r, e, ro, po);
        model(0, 1'b1, 32'h4004, 32'hA5A5A5A5, ee, k, er);
        tests++;
        if (e !== ee || lat !== 3) begin
            fails++;
            $display("FAIL wrap_write: err=%b lat=%0d expected %b 3", e, lat, ee);
        end
        txn(0, 1'b0, 32'h4, 32'h0, lat, r, e, ro, po);
        model(0, 1'b0, 32'h4, 32'h0, ee, k, er);
        tests++;
        if (r !== er || e !== 1'b0) begin
            fails++;
            $display("FAIL wrap_read: data=%h err=%b expected %h 0", r, e, er);
        end
    endtask

    task automatic test_latency1();
        int lat; bit [31:0] r, er, d; bit e, k, ro, po, ee;
        d = $urandom;
        txn(1, 1'b1, 32'h40, d, lat, r, e, ro, po);
        model(1, 1'b1, 32'h40, d, ee, k, er);
        txn(1, 1'b0, 32'h40, 32'h0, lat, r, e, ro, po);
        model(1, 1'b0, 32'h40, 32'h0, ee, k, er);
        tests++;
        if (lat !== 1 || !ro || !po) begin
            fails++;
            $display("FAIL lat1_timing: lat=%0d ready_low=%0d ready_back=%0d expected 1 1 1", lat, ro, po);
        end
        tests++;
        if (r !== d) begin
            fails++;
            $display("FAIL lat1_data: data=%h expected %h", r, d);
        end
    endtask

    task automatic test_random();
        int lat, s; bit [31:0] r, er, a, d; bit e, k, ro, po, ee, w;
        for (int i = 0; i < 80; i++) begin
            s = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            a = {($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'h0, 12'($urandom_range(0, 15)), 2'($urandom)};
            d = $urandom;
            txn(s, w, a, d, lat, r, e, ro, po);
            model(s, w, a, d, ee, k, er);
            tests++;
            if (lat !== lat_of(s) || !ro || !po || e !== ee) begin
                fails++;
                $display("FAIL rand_timing[%0d]: dut=%0d lat=%0d ready_low=%0d after_ok=%0d err=%b expected %0d 1 1 %b",
                         i, s, lat, ro, po, e, lat_of(s), ee);
            end
            if (k) begin
                tests++;
                if (r !== er) begin
                    fails++;
                    $display("FAIL rand_data[%0d]: dut=%0d addr=%h data=%h expected %h", i, s, a, r, er);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_reset_abort();
        test_wrap();
        test_latency1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
